// File: rtl/kernel_engine_ctrl_if.sv
// Register-slave side bundle of the kernel engine controller. The register
// slave (master modport) posts commands, arguments and counter controls, and
// reads back the status word array produced by the engine (slave modport).
interface kernel_engine_ctrl_if #(
    parameter int ARG_NUM = 32,
    parameter int WORD_W  = 32
);
    logic [7:0]                     kernel_command;
    logic                           kernel_command_new;
    logic [ARG_NUM-1:0][WORD_W-1:0] kernel_engine_arg;
    logic                           counter_reset;
    logic                           counter_start;
    logic                           state_lock_cmd;
    logic [ARG_NUM-1:0][WORD_W-1:0] kernel_engine_status;

    modport master (
        output kernel_command,
        output kernel_command_new,
        output kernel_engine_arg,
        output counter_reset,
        output counter_start,
        output state_lock_cmd,
        input  kernel_engine_status
    );

    modport slave (
        input  kernel_command,
        input  kernel_command_new,
        input  kernel_engine_arg,
        input  counter_reset,
        input  counter_start,
        input  state_lock_cmd,
        output kernel_engine_status
    );
endinterface

// File: rtl/kernel_engine_ctrl.sv
// Kernel engine controller: decodes commands from the register slave,
// sequences the Ariane core through reset/run/done, keeps the error/abort
// bookkeeping and the software-driven inner counter, and publishes status.
module kernel_engine_ctrl #(
    parameter int ARG_NUM  = 32,
    parameter int WORD_W   = 32,
    parameter int RST_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    kernel_engine_ctrl_if.slave   regBus,
    input  logic                  core_done_i,
    input  logic [WORD_W-1:0]     core_exit_code_i,
    output logic                  core_rst_no_o,
    output logic                  core_run_o,
    output logic [WORD_W-1:0]     core_boot_addr_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_ABORT = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h04;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3
    } stateT;

    stateT             state_q, state_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic [WORD_W-1:0] runCycles_q, runCycles_d;
    logic [WORD_W-1:0] exitCode_q, exitCode_d;
    logic [WORD_W-1:0] bootAddr_q, bootAddr_d;
    logic [WORD_W-1:0] innerCnt_q, innerCnt_d;
    logic [15:0]       errCnt_q, errCnt_d;
    logic [15:0]       abortCnt_q, abortCnt_d;
    logic              lock_q, lock_d;
    logic              coreRstNo_q, coreRstNo_d;
    logic              coreRun_q, coreRun_d;

    logic              cmdValid;
    logic              idleOrDone;
    logic              errBump;
    logic              abortBump;
    logic [ARG_NUM-1:0][WORD_W-1:0] statusW;
    logic              unusedArgBits;

    assign cmdValid   = regBus.kernel_command_new && !regBus.state_lock_cmd;
    assign idleOrDone = (state_q == IDLE) || (state_q == DONE);

    // Only argument word 1 (boot address) is consumed; fold the rest away.
    assign unusedArgBits = ^regBus.kernel_engine_arg;

    // Next-state logic: automatic RESET/RUN progress first, then any accepted
    // command overrides it, so ABORT beats a same-cycle core_done.
    always_comb begin
        state_d     = state_q;
        holdCnt_d   = holdCnt_q;
        runCycles_d = runCycles_q;
        exitCode_d  = exitCode_q;
        bootAddr_d  = bootAddr_q;
        errCnt_d    = errCnt_q;
        abortCnt_d  = abortCnt_q;
        lock_d      = regBus.state_lock_cmd;
        errBump     = 1'b0;
        abortBump   = 1'b0;

        if (regBus.counter_reset) begin
            innerCnt_d = '0;
        end else if (regBus.counter_start) begin
            innerCnt_d = innerCnt_q + 1'b1;
        end else begin
            innerCnt_d = innerCnt_q;
        end

        case (state_q)
            RESET: begin
                holdCnt_d = holdCnt_q + 1'b1;
                if (holdCnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (runCycles_q != '1) begin
                    runCycles_d = runCycles_q + 1'b1;
                end
                if (core_done_i) begin
                    state_d    = DONE;
                    exitCode_d = core_exit_code_i;
                end
            end
            default: begin
            end
        endcase

        if (cmdValid) begin
            case (regBus.kernel_command)
                OP_START: begin
                    if (idleOrDone) begin
                        state_d     = RESET;
                        bootAddr_d  = regBus.kernel_engine_arg[1];
                        holdCnt_d   = '0;
                        runCycles_d = '0;
                    end else begin
                        errBump = 1'b1;
                    end
                end
                OP_ABORT: begin
                    if (!idleOrDone) begin
                        state_d    = IDLE;
                        exitCode_d = exitCode_q;
                        abortBump  = 1'b1;
                    end else begin
                        errBump = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    if (idleOrDone) begin
                        errCnt_d   = '0;
                        abortCnt_d = '0;
                        exitCode_d = '0;
                    end else begin
                        errBump = 1'b1;
                    end
                end
                default: begin
                    errBump = 1'b1;
                end
            endcase
        end

        if (errBump && (errCnt_q != 16'hFFFF)) begin
            errCnt_d = errCnt_q + 16'd1;
        end
        if (abortBump && (abortCnt_q != 16'hFFFF)) begin
            abortCnt_d = abortCnt_q + 16'd1;
        end

        coreRstNo_d = (state_d == RUN) || (state_d == DONE);
        coreRun_d   = (state_d == RUN);
    end

    // State and bookkeeping registers; core controls are registered so they
    // change on the same edge as the state they decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            runCycles_q <= '0;
            exitCode_q  <= '0;
            bootAddr_q  <= '0;
            innerCnt_q  <= '0;
            errCnt_q    <= '0;
            abortCnt_q  <= '0;
            lock_q      <= 1'b0;
            coreRstNo_q <= 1'b0;
            coreRun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdCnt_q   <= holdCnt_d;
            runCycles_q <= runCycles_d;
            exitCode_q  <= exitCode_d;
            bootAddr_q  <= bootAddr_d;
            innerCnt_q  <= innerCnt_d;
            errCnt_q    <= errCnt_d;
            abortCnt_q  <= abortCnt_d;
            lock_q      <= lock_d;
            coreRstNo_q <= coreRstNo_d;
            coreRun_q   <= coreRun_d;
        end
    end

    // Status word array served on AXI-lite reads; words past 5 read as zero.
    always_comb begin
        statusW    = '0;
        statusW[0] = WORD_W'({lock_q, 5'b0, state_q});
        statusW[1] = exitCode_q;
        statusW[2] = runCycles_q;
        statusW[3] = WORD_W'({abortCnt_q, errCnt_q});
        statusW[4] = innerCnt_q;
        statusW[5] = bootAddr_q;
    end

    assign regBus.kernel_engine_status = statusW;
    assign core_rst_no_o    = coreRstNo_q;
    assign core_run_o       = coreRun_q;
    assign core_boot_addr_o = bootAddr_q;

endmodule

// File: tb/tb_kernel_engine_ctrl.sv
// Testbench for kernel_engine_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the command rules.
module tb_kernel_engine_ctrl;

    localparam int P_ARG  = 32;
    localparam int P_W    = 32;
    localparam int P_HOLD = 16;

    localparam int S_IDLE  = 0;
    localparam int S_RESET = 1;
    localparam int S_RUN   = 2;
    localparam int S_DONE  = 3;

    typedef logic [P_ARG-1:0][P_W-1:0] statusT;

    logic            clk;
    logic            rstn;
    logic            core_done;
    logic [P_W-1:0]  core_exit_code;
    logic            core_rst_no;
    logic            core_run;
    logic [P_W-1:0]  core_boot_addr;

    logic            core_done8;
    logic [7:0]      core_exit_code8;
    logic            core_rst_no8;
    logic            core_run8;
    logic [7:0]      core_boot_addr8;

    int nCompared;
    int nMismatched;

    int          mState;
    logic [31:0] mExit;
    logic [31:0] mRun;
    logic [31:0] mCnt;
    logic [31:0] mBoot;
    int          mErr;
    int          mAbort;
    int          mHold;
    logic        mLock;

    kernel_engine_ctrl_if #(.ARG_NUM(P_ARG), .WORD_W(P_W)) busIf ();
    kernel_engine_ctrl_if #(.ARG_NUM(6), .WORD_W(8)) busIf8 ();

    kernel_engine_ctrl #(.ARG_NUM(P_ARG), .WORD_W(P_W), .RST_HOLD(P_HOLD)) u_dut (
        .clk              (clk),
        .rstn             (rstn),
        .regBus           (busIf.slave),
        .core_done_i      (core_done),
        .core_exit_code_i (core_exit_code),
        .core_rst_no_o    (core_rst_no),
        .core_run_o       (core_run),
        .core_boot_addr_o (core_boot_addr)
    );

    kernel_engine_ctrl #(.ARG_NUM(6), .WORD_W(8), .RST_HOLD(1)) u_dut8 (
        .clk              (clk),
        .rstn             (rstn),
        .regBus           (busIf8.slave),
        .core_done_i      (core_done8),
        .core_exit_code_i (core_exit_code8),
        .core_rst_no_o    (core_rst_no8),
        .core_run_o       (core_run8),
        .core_boot_addr_o (core_boot_addr8)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        mState = S_IDLE;
        mExit  = '0;
        mRun   = '0;
        mCnt   = '0;
        mBoot  = '0;
        mErr   = 0;
        mAbort = 0;
        mHold  = 0;
        mLock  = 1'b0;
    endtask

    // Applies the rules for one clock edge using the inputs seen before it
    task automatic model_edge();
        int ns;
        bit errHit;
        bit aborted;
        bit quiet;
        ns      = mState;
        errHit  = 0;
        aborted = 0;
        quiet   = (mState == S_IDLE) || (mState == S_DONE);
        if (busIf.counter_reset) mCnt = '0;
        else if (busIf.counter_start) mCnt = mCnt + 32'd1;
        if (busIf.kernel_command_new && !busIf.state_lock_cmd) begin
            case (busIf.kernel_command)
                8'h01: begin
                    if (quiet) begin
                        ns = S_RESET; mBoot = busIf.kernel_engine_arg[1]; mHold = 0; mRun = '0;
                    end else errHit = 1;
                end
                8'h02: begin
                    if (!quiet) begin
                        ns = S_IDLE; aborted = 1;
                        if (mAbort < 65535) mAbort++;
                    end else errHit = 1;
                end
                8'h04: begin
                    if (quiet) begin
                        mErr = 0; mAbort = 0; mExit = '0;
                    end else errHit = 1;
                end
                default: errHit = 1;
            endcase
        end
        if (errHit && mErr < 65535) mErr++;
        if (mState == S_RESET && !aborted) begin
            if (mHold == P_HOLD - 1) ns = S_RUN;
            mHold++;
        end
        if (mState == S_RUN) begin
            if (mRun != 32'hFFFF_FFFF) mRun = mRun + 32'd1;
            if (core_done && !aborted) begin
                ns = S_DONE; mExit = core_exit_code;
            end
        end
        mLock  = busIf.state_lock_cmd;
        mState = ns;
    endtask

    function automatic statusT exp_status();
        statusT s;
        s    = '0;
        s[0] = {23'd0, mLock, 5'd0, mState[2:0]};
        s[1] = mExit;
        s[2] = mRun;
        s[3] = {mAbort[15:0], mErr[15:0]};
        s[4] = mCnt;
        s[5] = mBoot;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op);
        busIf.kernel_command     = op;
        busIf.kernel_command_new = 1'b1;
        tick();
        busIf.kernel_command_new = 1'b0;
        busIf.kernel_command     = 8'h00;
    endtask

    task automatic wait_run(input int bound);
        int n;
        n = 0;
        while (core_run !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        nCompared++;
        if (core_run !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL wait_run: core_run got %b required 1 within %0d cycles", core_run, bound);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        core_done = 1'b0; core_exit_code = '0;
        core_done8 = 1'b0; core_exit_code8 = '0;
        busIf.kernel_command = '0; busIf.kernel_command_new = 1'b0;
        busIf.kernel_engine_arg = '0; busIf.counter_reset = 1'b0;
        busIf.counter_start = 1'b0; busIf.state_lock_cmd = 1'b0;
        busIf8.kernel_command = '0; busIf8.kernel_command_new = 1'b0;
        busIf8.kernel_engine_arg = '0; busIf8.counter_reset = 1'b0;
        busIf8.counter_start = 1'b0; busIf8.state_lock_cmd = 1'b0;
        model_reset();
        #22;
        nCompared++;
        if ({core_rst_no, core_run} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_core: rst_no/run got %b%b required 00", core_rst_no, core_run);
        end
        nCompared++;
        if (core_boot_addr !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_boot: got %h required 0", core_boot_addr);
        end
        nCompared++;
        if (busIf.kernel_engine_status !== statusT'(0)) begin
            nMismatched++;
            $display("[TB] FAIL reset_status: got %h required 0", busIf.kernel_engine_status);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_start_boot();
        busIf.kernel_engine_arg[1] = 32'h8000_0000;
        send_cmd(8'h01);
        nCompared++;
        if (busIf.kernel_engine_status[0] !== 32'd1) begin
            nMismatched++;
            $display("[TB] FAIL start_state: got %h required 1", busIf.kernel_engine_status[0]);
        end
        for (int k = 0; k < P_HOLD; k++) begin
            nCompared++;
            if (core_rst_no !== 1'b0 || core_run !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL start_hold[%0d]: rst_no/run got %b%b required 00", k, core_rst_no, core_run);
            end
            if (k < P_HOLD - 1) tick();
        end
        tick();
        nCompared++;
        if (core_rst_no !== 1'b1 || core_run !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL start_run: rst_no/run got %b%b required 11", core_rst_no, core_run);
        end
        nCompared++;
        if (busIf.kernel_engine_status[5] !== 32'h8000_0000 || busIf.kernel_engine_status[0] !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL start_status: [5]=%h [0]=%h required 80000000 and 2",
                     busIf.kernel_engine_status[5], busIf.kernel_engine_status[0]);
        end
    endtask

    task automatic test_run_done();
        repeat (99) tick();
        core_done = 1'b1; core_exit_code = 32'h2A;
        tick();
        core_done = 1'b0; core_exit_code = '0;
        nCompared++;
        if (busIf.kernel_engine_status[0] !== 32'd3 || busIf.kernel_engine_status[1] !== 32'h2A ||
            busIf.kernel_engine_status[2] !== 32'd100 || core_run !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL run_done: [0]=%h [1]=%h [2]=%0d run=%b required 3 2a 100 0",
                     busIf.kernel_engine_status[0], busIf.kernel_engine_status[1],
                     busIf.kernel_engine_status[2], core_run);
        end
        nCompared++;
        if (busIf.kernel_engine_status !== exp_status()) begin
            nMismatched++;
            $display("[TB] FAIL run_done_model: got %h required %h", busIf.kernel_engine_status, exp_status());
        end
    endtask

    task automatic test_commands();
        send_cmd(8'h01);
        wait_run(40);
        send_cmd(8'h01);
        send_cmd(8'h7F);
        nCompared++;
        if (busIf.kernel_engine_status[3] !== 32'h0000_0002 || busIf.kernel_engine_status[0] !== 32'd2) begin
            nMismatched++;
            $display("[TB] FAIL cmd_errors: [3]=%h [0]=%h required 00000002 and 2",
                     busIf.kernel_engine_status[3], busIf.kernel_engine_status[0]);
        end
        send_cmd(8'h02);
        nCompared++;
        if (busIf.kernel_engine_status[0] !== 32'd0 || busIf.kernel_engine_status[3] !== 32'h0001_0002) begin
            nMismatched++;
            $display("[TB] FAIL cmd_abort: [0]=%h [3]=%h required 0 and 00010002",
                     busIf.kernel_engine_status[0], busIf.kernel_engine_status[3]);
        end
        send_cmd(8'h04);
        nCompared++;
        if (busIf.kernel_engine_status[3] !== 32'd0 || busIf.kernel_engine_status[1] !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL cmd_clear: [3]=%h [1]=%h required 0 and 0",
                     busIf.kernel_engine_status[3], busIf.kernel_engine_status[1]);
        end
        nCompared++;
        if (busIf.kernel_engine_status !== exp_status()) begin
            nMismatched++;
            $display("[TB] FAIL cmd_model: got %h required %h", busIf.kernel_engine_status, exp_status());
        end
    endtask

    task automatic test_lock();
        busIf.state_lock_cmd = 1'b1;
        tick();
        send_cmd(8'h01);
        tick();
        nCompared++;
        if (busIf.kernel_engine_status[0] !== 32'h100 || busIf.kernel_engine_status[3] !== 32'd0 ||
            core_rst_no !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL lock_drop: [0]=%h [3]=%h rst_no=%b required 100 0 0",
                     busIf.kernel_engine_status[0], busIf.kernel_engine_status[3], core_rst_no);
        end
        busIf.state_lock_cmd = 1'b0;
        tick();
    endtask

    task automatic test_counter();
        busIf.counter_start = 1'b1;
        repeat (10) tick();
        busIf.counter_start = 1'b0;
        nCompared++;
        if (busIf.kernel_engine_status[4] !== 32'd10) begin
            nMismatched++;
            $display("[TB] FAIL counter_ten: got %0d required 10", busIf.kernel_engine_status[4]);
        end
        busIf.counter_start = 1'b1; busIf.counter_reset = 1'b1;
        tick();
        busIf.counter_start = 1'b0; busIf.counter_reset = 1'b0;
        nCompared++;
        if (busIf.kernel_engine_status[4] !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL counter_reset_wins: got %0d required 0", busIf.kernel_engine_status[4]);
        end
    endtask

    task automatic test_small_dut();
        busIf8.counter_start = 1'b1;
        repeat (255) tick();
        nCompared++;
        if (busIf8.kernel_engine_status[4] !== 8'hFF) begin
            nMismatched++;
            $display("[TB] FAIL wrap_top: got %h required ff", busIf8.kernel_engine_status[4]);
        end
        tick();
        busIf8.counter_start = 1'b0;
        nCompared++;
        if (busIf8.kernel_engine_status[4] !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL wrap_zero: got %h required 00", busIf8.kernel_engine_status[4]);
        end
        busIf8.kernel_engine_arg[1] = 8'hC3;
        busIf8.kernel_command = 8'h01; busIf8.kernel_command_new = 1'b1;
        tick();
        busIf8.kernel_command = 8'h00; busIf8.kernel_command_new = 1'b0;
        nCompared++;
        if (core_run8 !== 1'b0 || core_rst_no8 !== 1'b0 || core_boot_addr8 !== 8'hC3) begin
            nMismatched++;
            $display("[TB] FAIL hold1_reset: run=%b rst_no=%b boot=%h required 0 0 c3",
                     core_run8, core_rst_no8, core_boot_addr8);
        end
        tick();
        nCompared++;
        if (core_run8 !== 1'b1 || core_rst_no8 !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL hold1_run: run=%b rst_no=%b required 1 1", core_run8, core_rst_no8);
        end
        repeat (300) tick();
        nCompared++;
        if (busIf8.kernel_engine_status[2] !== 8'hFF) begin
            nMismatched++;
            $display("[TB] FAIL run_saturate: got %h required ff", busIf8.kernel_engine_status[2]);
        end
    endtask

    task automatic test_abort_done();
        send_cmd(8'h01);
        wait_run(40);
        repeat (5) tick();
        busIf.kernel_command = 8'h02; busIf.kernel_command_new = 1'b1;
        core_done = 1'b1; core_exit_code = 32'h55;
        tick();
        busIf.kernel_command = 8'h00; busIf.kernel_command_new = 1'b0;
        core_done = 1'b0; core_exit_code = '0;
        nCompared++;
        if (busIf.kernel_engine_status[0] !== 32'd0 || busIf.kernel_engine_status[1] !== 32'd0 ||
            busIf.kernel_engine_status[3] !== 32'h0001_0000 || core_rst_no !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL abort_done: [0]=%h [1]=%h [3]=%h rst_no=%b required 0 0 00010000 0",
                     busIf.kernel_engine_status[0], busIf.kernel_engine_status[1],
                     busIf.kernel_engine_status[3], core_rst_no);
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        logic       expRstNo;
        logic       expRun;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h04;
                default: op = 8'($urandom);
            endcase
            busIf.kernel_command       = op;
            busIf.kernel_command_new   = ($urandom_range(0, 99) < 30);
            busIf.state_lock_cmd       = ($urandom_range(0, 9) == 0);
            busIf.counter_reset        = ($urandom_range(0, 19) == 0);
            busIf.counter_start        = 1'($urandom_range(0, 1));
            busIf.kernel_engine_arg[1] = $urandom;
            core_done                  = ($urandom_range(0, 19) == 0);
            core_exit_code             = $urandom;
            tick();
            expRstNo = (mState == S_RUN) || (mState == S_DONE);
            expRun   = (mState == S_RUN);
            nCompared++;
            if (busIf.kernel_engine_status !== exp_status()) begin
                nMismatched++;
                $display("[TB] FAIL random_status[%0d]: got %h required %h",
                         c, busIf.kernel_engine_status, exp_status());
            end
            nCompared++;
            if ({core_rst_no, core_run, core_boot_addr} !== {expRstNo, expRun, mBoot}) begin
                nMismatched++;
                $display("[TB] FAIL random_core[%0d]: got %b %b %h required %b %b %h",
                         c, core_rst_no, core_run, core_boot_addr, expRstNo, expRun, mBoot);
            end
        end
        busIf.kernel_command = '0; busIf.kernel_command_new = 1'b0;
        busIf.state_lock_cmd = 1'b0; busIf.counter_reset = 1'b0;
        busIf.counter_start = 1'b0; core_done = 1'b0; core_exit_code = '0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        if (mState == S_RESET || mState == S_RUN) send_cmd(8'h02);
        busIf.kernel_engine_arg[1] = 32'h1234_5678;
        send_cmd(8'h01);
        wait_run(40);
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        nCompared++;
        if ({core_rst_no, core_run} !== 2'b00 || core_boot_addr !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_core: rst_no/run %b%b boot %h required 00 0",
                     core_rst_no, core_run, core_boot_addr);
        end
        nCompared++;
        if (busIf.kernel_engine_status !== statusT'(0)) begin
            nMismatched++;
            $display("[TB] FAIL midrun_status: got %h required 0", busIf.kernel_engine_status);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    // Scenario sequence
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        $display("[TB] kernel_engine_ctrl bench start");
        test_reset();
        test_start_boot();
        test_run_done();
        test_commands();
        test_lock();
        test_counter();
        test_abort_done();
        test_small_dut();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
